// File: rtl/matrix_col_reader.sv
// ---------------------------------------------------------------------------
// matrix_col_reader
//   Column-major read sequencer for a row-major matrix held in a fixed-latency
//   buffer. A start pulse launches a walk over (row_max+1) x (col_max+1)
//   elements: row index fastest, then column. This is the transposed read that
//   feeds B-matrix columns into the MACC array. Read data is collected in a
//   4-entry FIFO and presented on a valid/ready stream with position tags and
//   framing flags.
//
// Ports
//   CLK, RST_L          clock, asynchronous active-low reset
//   VDD, GND            supply ties (no logic function)
//   start               begin a scan (ignored unless idle)
//   row_max, col_max    last row / column index, captured on accepted start
//   busy, done          scan in progress / one-cycle completion pulse
//   rd_en, rd_addr      buffer read strobe and row-major linear address
//   rd_data             buffer data, valid RD_LAT cycles after rd_en
//   out_*               output stream: data, row, col, last_col, last
//   out_valid/out_ready stream handshake
//
// RD_LAT must lie in 1..3.
// ---------------------------------------------------------------------------
module matrix_col_reader #(
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic          CLK,
    input  logic          RST_L,
    input  logic          VDD,
    input  logic          GND,
    input  logic          start,
    input  logic [9:0]    row_max,
    input  logic [9:0]    col_max,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [19:0]   rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic [9:0]    out_row,
    output logic [9:0]    out_col,
    output logic          out_last_col,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int TAG_W = 22;  // {row, col, last_col, last}

    state_t state_reg, state_next;
    logic   start_accept;

    // Scan position and addressing
    logic [9:0]  row_max_reg, col_max_reg;
    logic [19:0] stride_reg;
    logic [9:0]  row_reg, col_reg;
    logic [19:0] addr_reg;
    logic        issue_last_col, issue_last;
    logic [TAG_W-1:0] issue_tag;

    // Tag pipeline, aligned with the buffer read latency
    logic [RD_LAT-1:0] pipe_vld;
    logic [TAG_W-1:0]  pipe_tag [RD_LAT];
    logic [2:0]        in_flight;
    logic [3:0]        outstanding;
    logic              can_issue;

    // Output FIFO
    logic [DW-1:0]    fifo_data_reg [4];
    logic [TAG_W-1:0] fifo_tag_reg  [4];
    logic [1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [2:0]       count_reg;
    logic             fifo_push, fifo_pop;
    logic [TAG_W-1:0] head_tag;

    logic unused_supply;
    assign unused_supply = VDD ^ GND;

    assign issue_last_col = (row_reg == row_max_reg);
    assign issue_last     = issue_last_col && (col_reg == col_max_reg);
    assign issue_tag      = {row_reg, col_reg, issue_last_col, issue_last};
    assign rd_addr        = addr_reg;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + {2'b00, pipe_vld[i]};
        end
    end

    // Everything issued but not yet handed downstream, including the head
    // element that may be leaving this very cycle; capping at 4 guarantees
    // the FIFO can absorb every read still in flight.
    assign outstanding = {1'b0, in_flight} + {1'b0, count_reg};
    assign can_issue   = (outstanding < 4'd4);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        busy         = 1'b0;
        done         = 1'b0;
        rd_en        = 1'b0;
        start_accept = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = can_issue;
                if (can_issue && issue_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // The final element is always the youngest read, so once it
                // leaves the FIFO nothing remains buffered or in flight.
                // Leaving on that transfer places done right after it.
                if (fifo_pop && head_tag[0]) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan counters: strength-reduced addressing (add stride down a column,
    // restart at col+1 when the column ends).
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            row_max_reg <= '0;
            col_max_reg <= '0;
            stride_reg  <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            addr_reg    <= '0;
        end else if (start_accept) begin
            row_max_reg <= row_max;
            col_max_reg <= col_max;
            stride_reg  <= {10'd0, col_max} + 20'd1;
            row_reg     <= '0;
            col_reg     <= '0;
            addr_reg    <= '0;
        end else if (rd_en) begin
            if (issue_last_col) begin
                row_reg <= '0;
                if (issue_last) begin
                    col_reg  <= '0;
                    addr_reg <= '0;
                end else begin
                    col_reg  <= col_reg + 10'd1;
                    addr_reg <= {10'd0, col_reg} + 20'd1;
                end
            end else begin
                row_reg  <= row_reg + 10'd1;
                addr_reg <= addr_reg + stride_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: stage RD_LAT-1 is valid in the same cycle as rd_data.
    // Clearing it on reset discards data returning for pre-reset reads.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            logic             vld_in;
            logic [TAG_W-1:0] tag_in;
            logic             vld_reg;
            logic [TAG_W-1:0] tag_reg;

            if (gi == 0) begin : g_head
                assign vld_in = rd_en;
                assign tag_in = issue_tag;
            end else begin : g_tail
                assign vld_in = pipe_vld[gi-1];
                assign tag_in = pipe_tag[gi-1];
            end

            always_ff @(posedge CLK or negedge RST_L) begin
                if (!RST_L) begin
                    vld_reg <= 1'b0;
                    tag_reg <= '0;
                end else begin
                    vld_reg <= vld_in;
                    tag_reg <= tag_in;
                end
            end

            assign pipe_vld[gi] = vld_reg;
            assign pipe_tag[gi] = tag_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output FIFO; the head entry drives the stream directly so out_* hold
    // steady while stalled.
    // ------------------------------------------------------------------
    assign fifo_push = pipe_vld[RD_LAT-1];
    assign out_valid = (count_reg != 3'd0);
    assign fifo_pop  = out_valid && out_ready;
    assign head_tag  = fifo_tag_reg[rd_ptr_reg];

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_tag_reg[i]  <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_push) begin
                fifo_data_reg[wr_ptr_reg] <= rd_data;
                fifo_tag_reg[wr_ptr_reg]  <= pipe_tag[RD_LAT-1];
                wr_ptr_reg                <= wr_ptr_reg + 2'd1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Zero the stream fields while nothing is valid.
    assign out_data     = out_valid ? fifo_data_reg[rd_ptr_reg] : '0;
    assign out_row      = out_valid ? head_tag[21:12] : '0;
    assign out_col      = out_valid ? head_tag[11:2]  : '0;
    assign out_last_col = out_valid && head_tag[1];
    assign out_last     = out_valid && head_tag[0];

endmodule

// File: tb/tb_matrix_col_reader.sv
module tb_matrix_col_reader;

    localparam int DW     = 16;
    localparam int RD_LAT = 2;

    logic          CLK;
    logic          RST_L;
    logic          VDD, GND;
    logic          start;
    logic [9:0]    row_max, col_max;
    logic          busy, done, rd_en;
    logic [19:0]   rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic [9:0]    out_row, out_col;
    logic          out_last_col, out_last, out_valid;
    logic          out_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mem_seed = 32'h1234_5678;

    matrix_col_reader #(.DW(DW), .RD_LAT(RD_LAT)) dut (
        .CLK(CLK), .RST_L(RST_L), .VDD(VDD), .GND(GND),
        .start(start), .row_max(row_max), .col_max(col_max),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_last_col(out_last_col), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Buffer contents: a seeded hash of the linear address.
    function automatic logic [DW-1:0] mem_word(input logic [19:0] a);
        logic [31:0] t;
        t = ({12'd0, a} * 32'h9E37_79B1) ^ mem_seed;
        return t[31:16] ^ t[15:0];
    endfunction

    // Fixed-latency buffer model (never reset, so stale returns do occur).
    logic [DW-1:0] bpipe [RD_LAT];
    always @(posedge CLK) begin
        bpipe[0] <= rd_en ? mem_word(rd_addr) : 16'hDEAD;
        for (int i = 1; i < RD_LAT; i++) bpipe[i] <= bpipe[i-1];
    end
    assign rd_data = bpipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          row;
        int          col;
        logic [DW-1:0] data;
        bit          lc;
        bit          l;
    } elem_t;

    // mode 0: ready always 1; 1: 1 on / 2 off; 2: random
    task automatic run_scan(input int r, input int c, input int mode,
                            input int inject_at, input bit start_in_done);
        int    exp_addr[$];
        elem_t exp_q[$];
        elem_t e;
        int    n, cyc, issued, xfers, first_valid, last_xfer, bound;
        bit    seen_done;

        mem_seed = $urandom;
        for (int cc = 0; cc <= c; cc++) begin
            for (int rr = 0; rr <= r; rr++) begin
                exp_addr.push_back(rr * (c + 1) + cc);
                e.row  = rr;
                e.col  = cc;
                e.data = mem_word(20'(rr * (c + 1) + cc));
                e.lc   = (rr == r);
                e.l    = (rr == r) && (cc == c);
                exp_q.push_back(e);
            end
        end
        n = (r + 1) * (c + 1);
        bound = n * 8 + 40;
        cyc = 0; issued = 0; xfers = 0; first_valid = -1; last_xfer = -1;
        seen_done = 0;

        while (1) begin
            @(negedge CLK);
            if (cyc == 0) begin
                start = 1'b1; row_max = 10'(r); col_max = 10'(c);
            end else begin
                start   = (cyc == inject_at);
                row_max = 10'($urandom);
                col_max = 10'($urandom);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase

            if (cyc == 0) begin
                check("idle_busy", busy, 0);
                check("idle_rd_en", rd_en, 0);
                check("idle_valid", out_valid, 0);
            end else begin
                check("busy", busy, 1);
            end

            if (rd_en) begin
                check("outstanding_lt4", (issued - xfers) < 4, 1);
                if (exp_addr.size() == 0) check("extra_rd", 0, 1);
                else check("rd_addr", rd_addr, exp_addr.pop_front());
                issued++;
            end
            if (mode == 0 && cyc >= 1 && cyc <= n) check("rd_en_sustained", rd_en, 1);

            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_out", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_row", out_row, e.row);
                        check("out_col", out_col, e.col);
                        check("out_data", out_data, e.data);
                        check("out_last_col", out_last_col, e.lc);
                        check("out_last", out_last, e.l);
                    end
                    xfers++;
                    if (out_last) last_xfer = cyc;
                end
            end

            if (done) begin
                seen_done = 1;
                check("done_timing", cyc, last_xfer + 1);
                check("remaining_out", exp_q.size(), 0);
                check("remaining_rd", exp_addr.size(), 0);
                if (start_in_done) begin
                    start = 1'b1; row_max = 10'd5; col_max = 10'd5;
                end
                break;
            end

            cyc++;
            if (cyc > bound) begin
                check("timeout", seen_done, 1);
                break;
            end
        end
        if (mode == 0) check("first_valid", first_valid, RD_LAT + 2);
        $display("scan rows=%0d cols=%0d mode=%0d elements=%0d cycles=%0d", r + 1, c + 1, mode, xfers, cyc);
    endtask

    task automatic reset_mid_scan();
        @(negedge CLK);
        start = 1'b1; row_max = 10'd3; col_max = 10'd3; out_ready = 1'b1;
        @(negedge CLK); start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_pre_busy", busy, 1);
        RST_L = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_flags", {out_row, out_col, out_last_col, out_last}, 0);
        check("rst_done", done, 0);
        #1 RST_L = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            check("post_rst_valid", out_valid, 0);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        $display("reset mid-scan applied with reads in flight");
    endtask

    initial begin
        RST_L = 1'b0; VDD = 1'b1; GND = 1'b0;
        start = 1'b0; row_max = '0; col_max = '0; out_ready = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_valid", out_valid, 0);
        check("reset_out", {out_data, out_row, out_col, out_last_col, out_last}, 0);
        RST_L = 1'b1;

        run_scan(1, 2, 0, -1, 0);
        run_scan(0, 0, 0, -1, 0);
        run_scan(3, 3, 1, 5, 0);
        run_scan(0, 4, 0, -1, 0);
        run_scan(1023, 1, 0, 100, 1);
        run_scan(2, 2, 0, -1, 0);
        for (int k = 0; k < 4; k++) begin
            run_scan($urandom_range(0, 7), $urandom_range(0, 7), 2, $urandom_range(2, 10), 0);
        end
        reset_mid_scan();
        run_scan(2, 3, 2, -1, 0);

        @(negedge CLK);
        start = 1'b0;
        check("final_busy", busy, 0);
        check("final_done", done, 0);
        @(negedge CLK);
        check("final_idle_rd_en", rd_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_col_reader.md
Name: matrix_col_reader

Overview:
Column-major matrix read sequencer, the read-side counterpart of the row-major 2D write counter in the MACC datapath. On a start pulse it walks a (row_max+1) x (col_max+1) matrix held row-major in a fixed-latency buffer. It issues one read per cycle down each column, then across columns, so the multiply-accumulate array receives B-matrix columns, which is a transposed read. Returned data is buffered and emitted on a valid/ready stream tagged with its row/col position and framing flags.

Parameters:
DW, 16, data width of buffer read data and output stream
RD_LAT, 2, fixed buffer read latency in cycles from rd_en to rd_data valid (legal range 1..3)

Ports:
CLK  input  1  clock
RST_L  input  1  asynchronous active-low reset
VDD  input  1  supply tie
GND  input  1  ground tie
start  input  1  one-cycle request to begin a scan; ignored while busy
row_max  input  10  last row index; sampled on accepted start
col_max  input  10  last column index; sampled on accepted start
busy  output  1  high from the cycle after an accepted start until the done pulse inclusive
done  output  1  one-cycle pulse when the last element is accepted downstream
rd_en  output  1  buffer read strobe
rd_addr  output  20  row-major linear address, row*(col_max+1)+col
rd_data  input  DW  read data, valid exactly RD_LAT cycles after rd_en
out_data  output  DW  stream data
out_row  output  10  row index of out_data
out_col  output  10  column index of out_data
out_last_col  output  1  element is the last row of its column
out_last  output  1  element is the final element of the matrix
out_valid  output  1  stream valid
out_ready  input  1  stream ready

Behaviour:
- Reset (async assert, sync deassert internally not required): FSM IDLE; busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data/out_row/out_col/flags=0; FIFO and in-flight pipeline cleared. Data returning after reset for pre-reset reads is discarded.
- FSM IDLE -> RUN on start. RUN -> DRAIN in the cycle the last read issues. DRAIN -> DONE when the FIFO is empty and nothing is in flight. DONE holds done=1 for one cycle, then -> IDLE.
- Scan order: row increments fastest, from 0 to row_max. Then row=0 and col+1. The last element is (row_max, col_max).
- Addressing: no multiplier. Within a column, addr += col_max+1. At column end, addr = col+1. All arithmetic is 20-bit unsigned, with no overflow for the 10-bit limits.
- Issue rule: rd_en=1 in RUN when (in_flight + fifo_count) < 4. The internal FIFO is 4 entries, each holding data, row, col, last_col and last.
- Issue tags: row, col and flags travel with each read through an RD_LAT-deep shift pipeline. rd_data is written to the FIFO in the cycle it is valid.
- Output timing: out_valid is the registered FIFO-not-empty signal. A transfer occurs when out_valid && out_ready.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Throughput: with out_ready held high, one element per cycle sustained. The first out_valid occurs RD_LAT+2 cycles after the start cycle.
- done asserts the cycle after the out_last transfer.
- Boundaries:
  - row_max=col_max=0: single read at addr 0, out_last=out_last_col=1.
  - row_max=0: every element has out_last_col=1.
  - start during busy (including the DONE cycle): ignored.
  - row_max/col_max changes while busy: no effect.
  - out_ready low indefinitely: issue stalls at 4 outstanding, with no data loss or overwrite.
  - Reset mid-scan: returns to IDLE with no done pulse.

Test Plan:
- row_max=1, col_max=2, out_ready=1, RD_LAT=2:
  - rd_addr sequence 0,3,1,4,2,5 on consecutive cycles.
  - out (row,col) sequence (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
  - out_last_col on elements 2, 4 and 6.
  - out_last plus done timing per Behaviour.
- row_max=col_max=0: one rd_en at addr 0, one output with out_last=1, done pulses once, busy returns to 0.
- row_max=3, col_max=3, out_ready toggling 1-cycle on / 2-cycles off: all 16 elements delivered in column-major order with data equal to the model buffer contents, no duplicates or losses, and never more than 4 outstanding.
- row_max=1023, col_max=1 with out_ready=1: last rd_addr is 2047 and address wrap at the column boundary is correct (addr 2046 -> 1).
- A start pulse mid-scan and a start in the DONE cycle are both ignored; a new start one cycle after done begins a fresh scan at addr 0.
- RST_L asserted mid-scan with reads in flight: outputs go to 0 immediately; stale rd_data is not emitted; no done pulse; a new scan after reset completes correctly.
